// File: rtl/ldst_queue_alloc.sv
// ldst_queue_alloc: tail allocation, any-slot issue removal and compaction selects for a collapsing LDST queue
// Ports: clk, rst_n (async, active low); enq_valid/enq_ready/enq_data insert at the tail;
//   iss_valid/iss_idx remove one slot; shift_sel slot i takes slot i+1 this cycle;
//   ent_valid/ent_data collapsed slot state (slot 0 oldest); count occupancy;
//   iss_err registered pulse after an issue aimed at an empty slot.
// Option: LDST_QUEUE_BYPASS_EN lets an empty queue present an enqueued entry in slot 0 the same cycle.
`ifndef LDST_WIDTH
`define LDST_WIDTH 8
`endif
module ldst_queue_alloc #(
  parameter int W = `LDST_WIDTH,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [W-1:0]         enq_data,
  input  logic                 iss_valid,
  input  logic [IW-1:0]        iss_idx,
  output logic [DEPTH-1:0]     shift_sel,
  output logic [DEPTH-1:0]     ent_valid,
  output logic [DEPTH*W-1:0]   ent_data,
  output logic [IW:0]          count,
  output logic                 iss_err
);
  localparam logic [IW:0] L_DEPTH = (IW+1)'(DEPTH);
  localparam int NP = 1 << IW;
  logic [DEPTH-1:0] r_valid, w_nvalid, w_up_valid;
  logic [DEPTH-1:0][W-1:0] r_data, w_ndata, w_up_data, w_vis_data;
  logic [IW:0] r_count, w_wr_pos;
  logic [NP-1:0] w_vis_pad;
  logic r_err, w_byp, w_iss_fire, w_enq_fire, w_consume, w_wr, w_shift_fire;
`ifdef LDST_QUEUE_BYPASS_EN
  assign w_byp = (r_count == '0) & enq_valid;
`else
  assign w_byp = 1'b0;
`endif
  assign enq_ready = r_count < L_DEPTH;
  assign w_enq_fire = enq_valid & enq_ready;
  assign ent_valid = r_valid | {{(DEPTH-1){1'b0}}, w_byp};
  always_comb begin
    w_vis_data = r_data;
    if (w_byp) w_vis_data[0] = enq_data;
  end
  assign ent_data = w_vis_data;
  // padding to a power of two keeps out-of-range issue indices reading as empty
  assign w_vis_pad = NP'(ent_valid);
  assign w_iss_fire = iss_valid & w_vis_pad[iss_idx];
  // a bypassed entry issued in the same cycle never touches storage
  assign w_consume = w_byp & w_iss_fire;
  assign w_shift_fire = w_iss_fire & ~w_consume;
  assign w_wr = w_enq_fire & ~w_consume;
  assign w_wr_pos = r_count - {{IW{1'b0}}, w_shift_fire};
  assign w_up_valid = {1'b0, r_valid[DEPTH-1:1]};
  assign w_up_data = {{W{1'b0}}, r_data[DEPTH-1:1]};
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shift_sel[i] = w_shift_fire & (IW'(i) >= iss_idx);
      w_nvalid[i] = shift_sel[i] ? w_up_valid[i] : r_valid[i];
      w_ndata[i] = shift_sel[i] ? w_up_data[i] : r_data[i];
      if (w_wr && w_wr_pos == (IW+1)'(i)) begin
        w_nvalid[i] = 1'b1;
        w_ndata[i] = enq_data;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data <= '0;
      r_count <= '0;
      r_err <= 1'b0;
    end else begin
      r_valid <= w_nvalid;
      r_data <= w_ndata;
      r_count <= r_count + {{IW{1'b0}}, w_wr} - {{IW{1'b0}}, w_shift_fire};
      r_err <= iss_valid & ~w_iss_fire;
    end
  end
  assign count = r_count;
  assign iss_err = r_err;
endmodule

// File: tb/tb_ldst_queue_alloc.sv
// tb_ldst_queue_alloc: directed and randomized checks of ldst_queue_alloc against a queue-based model
`ifndef LDST_WIDTH
`define LDST_WIDTH 8
`endif
module tb_ldst_queue_alloc;
  localparam int W = `LDST_WIDTH;
  localparam int DEPTH = 4;
  localparam int IW = $clog2(DEPTH);
  localparam logic [W-1:0] A = W'(8'hA1), B = W'(8'hB2), C = W'(8'hC3), D = W'(8'hD4);
  localparam logic [W-1:0] E = W'(8'hE5), X = W'(8'h5A), Z = '0;
  logic clk = 0, rst_n = 1, enq_valid = 0, iss_valid = 0;
  logic [W-1:0] enq_data = '0;
  logic [IW-1:0] iss_idx = '0;
  logic enq_ready, iss_err;
  logic [DEPTH-1:0] shift_sel, ent_valid;
  logic [DEPTH*W-1:0] ent_data;
  logic [IW:0] count;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic exp_err = 0;

  ldst_queue_alloc dut (
    .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_data(enq_data), .iss_valid(iss_valid), .iss_idx(iss_idx),
    .shift_sel(shift_sel), .ent_valid(ent_valid), .ent_data(ent_data),
    .count(count), .iss_err(iss_err)
  );

  always #5 clk = ~clk;

  function automatic bit byp_now();
`ifdef LDST_QUEUE_BYPASS_EN
    return q.size() == 0 && enq_valid;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int vis_n();
    return byp_now() ? 1 : q.size();
  endfunction

  function automatic bit fire_now();
    return iss_valid && int'(iss_idx) < vis_n();
  endfunction

  function automatic logic [DEPTH-1:0] exp_valid();
    logic [DEPTH-1:0] v = '0;
    for (int i = 0; i < vis_n(); i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [DEPTH*W-1:0] exp_data();
    logic [DEPTH*W-1:0] r = '0;
    if (byp_now()) r[W-1:0] = enq_data;
    else for (int i = 0; i < q.size(); i++) r[i*W +: W] = q[i];
    return r;
  endfunction

  function automatic logic [DEPTH-1:0] exp_shift();
    logic [DEPTH-1:0] v = '0;
    if (fire_now() && !byp_now())
      for (int i = 0; i < DEPTH; i++) v[i] = (i >= int'(iss_idx));
    return v;
  endfunction

  task automatic drive(input bit ev, input logic [W-1:0] ed, input bit iv, input int ii);
    enq_valid = ev;
    enq_data = ed;
    iss_valid = iv;
    iss_idx = IW'(ii);
  endtask

  task automatic tick();
    bit f = fire_now();
    bit b = byp_now();
    bit rdy = q.size() < DEPTH;
    bit ev = enq_valid;
    bit iv = iss_valid;
    int idx = int'(iss_idx);
    logic [W-1:0] d = enq_data;
    @(posedge clk);
    #1;
    exp_err = iv && !f;
    if (!b) begin
      if (f) q.delete(idx);
      if (ev && rdy) q.push_back(d);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_tests++; if (ent_valid !== '0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ent_valid); end
    n_tests++; if (ent_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", ent_data); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (iss_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", iss_err); end
    n_tests++; if (shift_sel !== '0) begin n_fail++; $display("FAIL reset_shift got=%b exp=0", shift_sel); end
    n_tests++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", enq_ready); end
    @(posedge clk);
    #1 rst_n = 1;
    q.delete();
    exp_err = 0;
  endtask

  task automatic test_fill();
    logic [W-1:0] vals[4] = '{A, B, C, D};
    for (int i = 0; i < 4; i++) begin
      drive(1, vals[i], 0, 0);
      #1;
      n_tests++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d got=%b exp=1", i, enq_ready); end
      tick();
      n_tests++; if (count !== (IW+1)'(i + 1)) begin n_fail++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i + 1); end
    end
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (ent_data !== {D, C, B, A}) begin n_fail++; $display("FAIL fill_data got=%h exp=%h", ent_data, {D, C, B, A}); end
    n_tests++; if (ent_valid !== 4'b1111) begin n_fail++; $display("FAIL fill_valid got=%b exp=1111", ent_valid); end
    n_tests++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got=%b exp=0", enq_ready); end
  endtask

  task automatic test_issue_mid();
    drive(0, Z, 1, 1);
    #1;
    n_tests++; if (shift_sel !== 4'b1110) begin n_fail++; $display("FAIL mid_shift got=%b exp=1110", shift_sel); end
    tick();
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (ent_valid !== 4'b0111) begin n_fail++; $display("FAIL mid_valid got=%b exp=0111", ent_valid); end
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_count got=%0d exp=3", count); end
    n_tests++; if (ent_data !== {Z, D, C, A}) begin n_fail++; $display("FAIL mid_data got=%h exp=%h", ent_data, {Z, D, C, A}); end
  endtask

  task automatic test_enq_iss();
    drive(1, E, 1, 0);
    #1;
    n_tests++; if (shift_sel !== 4'b1111) begin n_fail++; $display("FAIL ei_shift got=%b exp=1111", shift_sel); end
    tick();
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (ent_data !== {Z, E, D, C}) begin n_fail++; $display("FAIL ei_data got=%h exp=%h", ent_data, {Z, E, D, C}); end
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL ei_count got=%0d exp=3", count); end
    n_tests++; if (iss_err !== 1'b0) begin n_fail++; $display("FAIL ei_err got=%b exp=0", iss_err); end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 0;
    #1;
    n_tests++; if (ent_valid !== '0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", ent_valid); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", count); end
    q.delete();
    exp_err = 0;
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_err();
    drive(1, A, 0, 0);
    tick();
    drive(0, Z, 1, 2);
    #1;
    n_tests++; if (shift_sel !== '0) begin n_fail++; $display("FAIL err_shift got=%b exp=0", shift_sel); end
    tick();
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (iss_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%b exp=1", iss_err); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL err_count got=%0d exp=1", count); end
    n_tests++; if (ent_data !== {Z, Z, Z, A}) begin n_fail++; $display("FAIL err_data got=%h exp=%h", ent_data, {Z, Z, Z, A}); end
    tick();
    n_tests++; if (iss_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", iss_err); end
  endtask

  task automatic test_empty_enq_iss();
    drive(0, Z, 1, 0);
    tick();
    drive(1, X, 1, 0);
    #1;
`ifdef LDST_QUEUE_BYPASS_EN
    n_tests++; if (ent_valid !== 4'b0001) begin n_fail++; $display("FAIL byp_valid got=%b exp=0001", ent_valid); end
    n_tests++; if (ent_data[W-1:0] !== X) begin n_fail++; $display("FAIL byp_data got=%h exp=%h", ent_data[W-1:0], X); end
    n_tests++; if (shift_sel !== '0) begin n_fail++; $display("FAIL byp_shift got=%b exp=0", shift_sel); end
    tick();
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL byp_count got=%0d exp=0", count); end
    n_tests++; if (iss_err !== 1'b0) begin n_fail++; $display("FAIL byp_err got=%b exp=0", iss_err); end
`else
    n_tests++; if (ent_valid !== '0) begin n_fail++; $display("FAIL nb_valid got=%b exp=0", ent_valid); end
    tick();
    drive(0, Z, 0, 0);
    #1;
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL nb_count got=%0d exp=1", count); end
    n_tests++; if (iss_err !== 1'b1) begin n_fail++; $display("FAIL nb_err got=%b exp=1", iss_err); end
    n_tests++; if (ent_data[W-1:0] !== X) begin n_fail++; $display("FAIL nb_data got=%h exp=%h", ent_data[W-1:0], X); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1));
      #1;
      n_tests++; if (enq_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, enq_ready, q.size() < DEPTH); end
      n_tests++; if (ent_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, ent_valid, exp_valid()); end
      n_tests++; if (ent_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, ent_data, exp_data()); end
      n_tests++; if (shift_sel !== exp_shift()) begin n_fail++; $display("FAIL rnd_shift cyc=%0d got=%b exp=%b", n, shift_sel, exp_shift()); end
      n_tests++; if (count !== (IW+1)'(q.size())) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, count, q.size()); end
      n_tests++; if (iss_err !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", n, iss_err, exp_err); end
      tick();
    end
    drive(0, Z, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_issue_mid();
    test_enq_iss();
    test_reset_mid();
    test_err();
    test_empty_enq_iss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
